// File: rtl/cpu_pkg.sv
// Shared CPU definitions: field positions, widths and fetch state encoding.
package cpu_pkg;
    localparam int         PC_W        = 16;
    localparam int         INSTR_W     = 16;
    localparam int         OP_HI       = 15;
    localparam int         OP_LO       = 12;
    localparam logic [3:0] HALT_OP_DEF = 4'hF;

    typedef enum logic {
        FETCH = 1'b0,
        HALT  = 1'b1
    } fetch_state_e;

    function automatic logic [3:0] opcode(input logic [INSTR_W-1:0] instr);
        return instr[OP_HI:OP_LO];
    endfunction
endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instmem address/data, branch redirect, and decode handshake.
interface fetch_if
    import cpu_pkg::*;
#(
    parameter int PC_W = cpu_pkg::PC_W
);
    logic [PC_W-1:0]    mem_pc;
    logic               mem_en;
    logic [INSTR_W-1:0] mem_instr;
    logic               branch_taken;
    logic [PC_W-1:0]    branch_target;
    logic               id_ready;
    logic               if_valid;
    logic [INSTR_W-1:0] if_instr;
    logic [PC_W-1:0]    if_pc;
    logic               halted;
    logic [15:0]        fetch_count;

    modport master (
        output mem_pc, mem_en, if_valid, if_instr, if_pc, halted, fetch_count,
        input  mem_instr, branch_taken, branch_target, id_ready
    );

    modport slave (
        input  mem_pc, mem_en, if_valid, if_instr, if_pc, halted, fetch_count,
        output mem_instr, branch_taken, branch_target, id_ready
    );
endinterface

// File: rtl/fetch_unit_pipe_reg.sv
// Instruction register between fetch and decode: flush beats load beats drain/hold.
module fetch_pipe_reg
    import cpu_pkg::*;
#(
    parameter int PC_W = cpu_pkg::PC_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_load,
    input  logic               i_flush,
    input  logic               i_ready,
    input  logic [INSTR_W-1:0] i_instr,
    input  logic [PC_W-1:0]    i_pc,
    output logic               o_valid,
    output logic [INSTR_W-1:0] o_instr,
    output logic [PC_W-1:0]    o_pc
);
    logic               r_valid;
    logic [INSTR_W-1:0] r_instr;
    logic [PC_W-1:0]    r_pc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= 1'b0;
            r_instr <= '0;
            r_pc    <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_instr <= i_instr;
            r_pc    <= i_pc;
        end else if (r_valid && i_ready) begin
            // consumed with nothing behind it
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_instr = r_instr;
    assign o_pc    = r_pc;
endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, drives instmem, halts on the halt opcode, redirects on branch.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_VECTOR = 16'h0000,
    parameter logic [3:0]  HALT_OPCODE  = HALT_OP_DEF,
    parameter int          PC_W         = cpu_pkg::PC_W
) (
    input  logic  clk,
    input  logic  reset,
    fetch_if.master bus
);
    fetch_state_e       r_state;
    logic [PC_W-1:0]    r_pc;
    logic               r_halted;
    logic [15:0]        r_count;
    logic               w_valid;
    logic               w_load;
    logic               w_xfer;
    logic [INSTR_W-1:0] w_instr;
    logic [PC_W-1:0]    w_if_pc;

    assign w_load = (r_state == FETCH) && (!w_valid || bus.id_ready) && !bus.branch_taken;
    assign w_xfer = w_valid && bus.id_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= FETCH;
            r_pc     <= PC_W'(RESET_VECTOR);
            r_halted <= 1'b0;
            r_count  <= '0;
        end else begin
            if (w_xfer && r_count != 16'hFFFF)
                r_count <= r_count + 16'd1;
            if (bus.branch_taken) begin
                r_pc     <= bus.branch_target;
                r_state  <= FETCH;
                r_halted <= 1'b0;
            end else if (w_load) begin
                r_pc <= r_pc + 1'b1;
                if (opcode(bus.mem_instr) == HALT_OPCODE) begin
                    r_state  <= HALT;
                    r_halted <= 1'b1;
                end
            end
        end
    end

    fetch_pipe_reg #(.PC_W(PC_W)) u_pipe (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_load),
        .i_flush (bus.branch_taken),
        .i_ready (bus.id_ready),
        .i_instr (bus.mem_instr),
        .i_pc    (r_pc),
        .o_valid (w_valid),
        .o_instr (w_instr),
        .o_pc    (w_if_pc)
    );

    // gate with reset so instmem sees no request while reset is held
    assign bus.mem_en      = w_load & reset;
    assign bus.mem_pc      = r_pc;
    assign bus.if_valid    = w_valid;
    assign bus.if_instr    = w_instr;
    assign bus.if_pc       = w_if_pc;
    assign bus.halted      = r_halted;
    assign bus.fetch_count = r_count;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed-vector bench for fetch_unit with a combinational instmem model.
module tb_fetch_unit;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    logic [15:0] mem [0:65535];

    fetch_if #(.PC_W(16)) bus ();

    fetch_unit #(.RESET_VECTOR(16'h0000), .HALT_OPCODE(4'hF), .PC_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    assign bus.mem_instr = mem[bus.mem_pc];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
        mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'h4444;
        mem[5] = 16'hF000; mem[16'h0040] = 16'h5050; mem[16'hFFFF] = 16'hABCD;
        bus.branch_taken = 1'b0; bus.branch_target = 16'h0000; bus.id_ready = 1'b1;

        // reset state
        step;
        chk("rst_valid", 32'(bus.if_valid), 0);
        chk("rst_en", 32'(bus.mem_en), 0);
        chk("rst_pc", 32'(bus.mem_pc), 0);
        chk("rst_cnt", 32'(bus.fetch_count), 0);
        chk("rst_halt", 32'(bus.halted), 0);
        reset = 1'b1;
        #1;
        chk("t1_pc0", 32'(bus.mem_pc), 0);
        chk("t1_en0", 32'(bus.mem_en), 1);

        // test 1: stream three words
        step;
        chk("t1_instr0", 32'(bus.if_instr), 32'h1111);
        chk("t1_ifpc0", 32'(bus.if_pc), 0);
        chk("t1_pc1", 32'(bus.mem_pc), 1);
        chk("t1_cnt0", 32'(bus.fetch_count), 0);
        step;
        chk("t1_instr1", 32'(bus.if_instr), 32'h2222);
        chk("t1_ifpc1", 32'(bus.if_pc), 1);
        chk("t1_cnt1", 32'(bus.fetch_count), 1);
        step;
        chk("t1_instr2", 32'(bus.if_instr), 32'h3333);
        chk("t1_ifpc2", 32'(bus.if_pc), 2);
        chk("t1_pc3", 32'(bus.mem_pc), 3);
        chk("t1_cnt2", 32'(bus.fetch_count), 2);

        // test 2: backpressure
        bus.id_ready = 1'b0;
        #1;
        chk("t2_en_now", 32'(bus.mem_en), 0);
        for (int i = 0; i < 3; i++) begin
            step;
            chk("t2_instr", 32'(bus.if_instr), 32'h3333);
            chk("t2_ifpc", 32'(bus.if_pc), 2);
            chk("t2_valid", 32'(bus.if_valid), 1);
            chk("t2_pc", 32'(bus.mem_pc), 3);
            chk("t2_en", 32'(bus.mem_en), 0);
            chk("t2_cnt", 32'(bus.fetch_count), 2);
        end
        bus.id_ready = 1'b1;
        #1;
        chk("t2_en_resume", 32'(bus.mem_en), 1);
        step;
        chk("t2_instr3", 32'(bus.if_instr), 32'h4444);
        chk("t2_ifpc3", 32'(bus.if_pc), 3);
        chk("t2_cnt3", 32'(bus.fetch_count), 3);

        // test 3: branch flushes the valid instruction
        bus.branch_taken = 1'b1; bus.branch_target = 16'h0040;
        #1;
        chk("t3_en_br", 32'(bus.mem_en), 0);
        step;
        bus.branch_taken = 1'b0;
        #1;
        chk("t3_valid", 32'(bus.if_valid), 0);
        chk("t3_pc", 32'(bus.mem_pc), 32'h40);
        chk("t3_cnt", 32'(bus.fetch_count), 4);
        chk("t3_en", 32'(bus.mem_en), 1);
        step;
        chk("t3_ifpc", 32'(bus.if_pc), 32'h40);
        chk("t3_instr", 32'(bus.if_instr), 32'h5050);
        chk("t3_valid2", 32'(bus.if_valid), 1);
        chk("t3_cnt2", 32'(bus.fetch_count), 4);

        // test 4: halt opcode at address 5
        bus.branch_taken = 1'b1; bus.branch_target = 16'h0005;
        step;
        bus.branch_taken = 1'b0;
        step;
        chk("t4_instr", 32'(bus.if_instr), 32'hF000);
        chk("t4_ifpc", 32'(bus.if_pc), 5);
        chk("t4_valid", 32'(bus.if_valid), 1);
        chk("t4_halted", 32'(bus.halted), 1);
        chk("t4_en", 32'(bus.mem_en), 0);
        chk("t4_pc", 32'(bus.mem_pc), 6);
        step;
        chk("t4_drain", 32'(bus.if_valid), 0);
        chk("t4_pc_hold", 32'(bus.mem_pc), 6);
        chk("t4_en_hold", 32'(bus.mem_en), 0);
        chk("t4_cnt", 32'(bus.fetch_count), 6);
        step;
        chk("t4_still", 32'(bus.halted), 1);
        bus.branch_taken = 1'b1; bus.branch_target = 16'h0000;
        step;
        bus.branch_taken = 1'b0;
        #1;
        chk("t4_unhalt", 32'(bus.halted), 0);
        chk("t4_pc0", 32'(bus.mem_pc), 0);
        chk("t4_en_on", 32'(bus.mem_en), 1);
        step;
        chk("t4_refetch", 32'(bus.if_instr), 32'h1111);
        chk("t4_ifpc0", 32'(bus.if_pc), 0);

        // test 5: PC wrap
        bus.branch_taken = 1'b1; bus.branch_target = 16'hFFFF;
        step;
        bus.branch_taken = 1'b0;
        chk("t5_cnt", 32'(bus.fetch_count), 7);
        step;
        chk("t5_instr_ff", 32'(bus.if_instr), 32'hABCD);
        chk("t5_ifpc_ff", 32'(bus.if_pc), 32'hFFFF);
        chk("t5_wrap", 32'(bus.mem_pc), 0);
        step;
        chk("t5_instr_0", 32'(bus.if_instr), 32'h1111);
        chk("t5_ifpc_0", 32'(bus.if_pc), 0);
        chk("t5_cnt2", 32'(bus.fetch_count), 8);

        // test 6: asynchronous reset between edges
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_valid", 32'(bus.if_valid), 0);
        chk("t6_instr", 32'(bus.if_instr), 0);
        chk("t6_ifpc", 32'(bus.if_pc), 0);
        chk("t6_pc", 32'(bus.mem_pc), 0);
        chk("t6_en", 32'(bus.mem_en), 0);
        chk("t6_cnt", 32'(bus.fetch_count), 0);
        chk("t6_halt", 32'(bus.halted), 0);
        step;
        reset = 1'b1;
        step;
        chk("t6_restart", 32'(bus.if_instr), 32'h1111);
        chk("t6_restart_pc", 32'(bus.if_pc), 0);

        // counter saturation over a long uninterrupted stream
        mem[5] = 16'h0000;
        repeat (65540) step;
        chk("sat_cnt", 32'(bus.fetch_count), 32'hFFFF);
        chk("sat_run", 32'(bus.halted), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage that sits directly upstream of instmem and downstream-feeds the decoder. It owns the program counter and drives pc/enable into instmem. It captures the returned 16-bit instruction into an instruction register and presents it to decode with a valid/ready handshake. It also handles branch redirect/flush and a halt opcode.

Parameters:
RESET_VECTOR, 16'h0000, PC value loaded on reset
HALT_OPCODE, 4'hF, value of instr[15:12] that stops fetching
PC_W, 16, program counter / address width (instmem interface is 16)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
mem_pc  output  PC_W  address to instmem pc input; always equals PC register
mem_en  output  1  instmem enable; high only when a fetch is being accepted this cycle
mem_instr  input  16  instmem instruction output; combinational, valid in the same cycle as mem_pc/mem_en
branch_taken  input  1  redirect request from execute; single-cycle pulse
branch_target  input  PC_W  redirect address; sampled when branch_taken=1
id_ready  input  1  decoder can accept if_instr this cycle
if_valid  output  1  if_instr/if_pc hold a valid instruction
if_instr  output  16  captured instruction
if_pc  output  PC_W  address the captured instruction came from
halted  output  1  fetch stopped by HALT_OPCODE
fetch_count  output  16  number of instructions accepted by decode; saturates at 16'hFFFF

Behaviour:
- Reset (reset=0, async): pc=RESET_VECTOR, if_valid=0, if_instr=0, if_pc=0, halted=0, fetch_count=0, state=FETCH. mem_en=0 while reset is asserted.
- States: FETCH, HALT. Encoding lives in the shared package.
- Define load = (state==FETCH) && (!if_valid || id_ready) && !branch_taken. mem_en = load, combinational.
- FETCH, load=1: at the edge, if_instr<=mem_instr, if_pc<=pc, if_valid<=1, pc<=pc+1. Fetch latency is 1 cycle: the address presented in cycle N appears on if_instr in cycle N+1.
- PC wraps from 16'hFFFF to 16'h0000 with no flag.
- Backpressure: if if_valid=1 and id_ready=0, if_instr/if_pc/if_valid and pc all hold, and mem_en=0.
- Drain without refill: if if_valid=1, id_ready=1 and no load occurs, if_valid<=0.
- Handshake: a transfer occurs when if_valid && id_ready. fetch_count increments by 1 per transfer and saturates at 16'hFFFF.
- Halt, entry: when a load captures mem_instr[15:12]==HALT_OPCODE, the state goes to HALT at the same edge. The halt instruction itself is still presented with if_valid=1. halted=1 from the next cycle.
- Halt, steady state: no loads, mem_en=0, pc holds at halt address+1. The pending halt instruction drains normally.
- Branch, priority: branch_taken=1 has highest priority over load, hold and HALT. At the edge: pc<=branch_target, if_valid<=0 (flush), state<=FETCH, halted<=0.
- Branch, counting: a transfer in the same cycle as branch_taken still counts in fetch_count. The decoder is required to ignore it.
- Branch, next fetch: the first fetch from branch_target occurs in the following cycle.
- Reset mid-operation: asynchronous return to reset values in the same instant. The in-flight instruction is discarded and the counter is cleared.

Decomposition:
- Shared package (cpu_pkg): PC_W, INSTR_W=16, OPCODE field position [15:12], HALT_OPCODE default, fetch state encoding (FETCH=1'b0, HALT=1'b1).
- One sub-module is natural: fetch_pipe_reg, the if_valid/if_instr/if_pc holding register with load/flush/hold controls.
- PC, FSM and counter stay in fetch_unit.

Test Plan:
1. Reset, then release with id_ready=1 and instmem preloaded 0:1111,1:2222,2:3333 -> mem_pc 0,1,2 on consecutive cycles; if_instr 1111,2222,3333 one cycle later with if_pc 0,1,2; fetch_count=3 after three transfers.
2. Hold id_ready=0 for 3 cycles while if_valid=1 at pc=2 -> if_instr/if_pc stable, mem_en=0, mem_pc stays 3, fetch_count unchanged; raising id_ready resumes fetch at address 3.
3. Pulse branch_taken with branch_target=16'h0040 while if_valid=1 -> next cycle if_valid=0 and mem_pc=0040; following cycle if_pc=0040.
4. Place F000 at address 5 -> F000 is presented with if_pc=5, then halted=1, mem_en=0, pc=6. A later branch to 0000 clears halted and fetches from 0000.
5. Branch to FFFF with mem[FFFF]=ABCD and mem[0000]=1111 -> if_pc FFFF then 0000; pc wraps with no stall.
6. Drive reset=0 between clock edges mid-stream -> all outputs return to reset values immediately without waiting for a clock edge; after release, fetch restarts at RESET_VECTOR.
